// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-memory fetch controller.
package imem_fetch_ctrl_pkg;

  localparam int unsigned XLEN            = 16;
  localparam int unsigned DEF_MEM_DEPTH   = 1024;
  localparam logic [XLEN-1:0] DEF_RESET_PC    = 16'h0000;
  localparam logic [XLEN-1:0] DEF_HALT_OPCODE = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  // Reduce a word address into the memory range, zero-extended to XLEN.
  function automatic logic [XLEN-1:0] mod_depth(input logic [XLEN-1:0] addr,
                                                input int unsigned depth);
    return XLEN'(32'(addr) % depth);
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_pc_reg.sv
// Program counter: reload, halt hold, branch redirect, stall hold, wrapping increment.
module pc_reg
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned     MEM_DEPTH = DEF_MEM_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_i,
  input  logic            reload_i,
  input  logic            halt_i,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_o
);

  localparam int unsigned LAST = MEM_DEPTH - 1;

  logic [XLEN-1:0] pc_q, pc_d;

  // Priority inside RUN: halt > branch > stall > increment.
  always_comb begin
    pc_d = pc_q;
    if (reload_i) begin
      pc_d = RESET_PC;
    end else if (run_i) begin
      if (halt_i) begin
        pc_d = pc_q;
      end else if (branch_i) begin
        pc_d = mod_depth(target_i, MEM_DEPTH);
      end else if (stall_i) begin
        pc_d = pc_q;
      end else if (32'(pc_q) >= LAST) begin
        pc_d = '0;
      end else begin
        pc_d = pc_q + XLEN'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller with optional boot loader (macro IMEM_LOADER_EN).
// Without the macro the LOAD state is unreachable and loader outputs are tied low.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned     MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC    = DEF_RESET_PC,
  parameter logic [XLEN-1:0] HALT_OPCODE = DEF_HALT_OPCODE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_req,
  input  logic            load_valid,
  input  logic [XLEN-1:0] load_data,
  output logic            load_ready,
  output logic            load_full,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_we,
  output logic [XLEN-1:0] imem_wdata,
  output logic [XLEN-1:0] pc,
  output logic            fetch_valid,
  output logic            halted
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] ld_ptr_q;
  logic            full_q;
  logic            halt_hit;
  logic            reload;

  assign halt_hit = (state_q == ST_RUN) && (instr == HALT_OPCODE);
  assign reload   = (state_q == ST_LOAD) && (state_d == ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
`ifdef IMEM_LOADER_EN
      ST_IDLE: state_d = load_req ? ST_LOAD : ST_RUN;
      ST_LOAD: state_d = load_req ? ST_LOAD : ST_IDLE;
      ST_RUN:  state_d = halt_hit ? ST_HALT : ST_RUN;
      ST_HALT: state_d = load_req ? ST_LOAD : ST_HALT;
`else
      ST_IDLE: state_d = ST_RUN;
      ST_LOAD: state_d = ST_IDLE;
      ST_RUN:  state_d = halt_hit ? ST_HALT : ST_RUN;
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory port and status decode; writes land at the edge ending the accept cycle.
  always_comb begin
    fetch_valid = (state_q == ST_RUN);
    halted      = (state_q == ST_HALT);
    imem_wdata  = load_data;
    imem_addr   = (state_q == ST_LOAD) ? ld_ptr_q : pc;
`ifdef IMEM_LOADER_EN
    load_ready  = (state_q == ST_LOAD) && !full_q;
    imem_we     = load_valid && load_ready;
`else
    load_ready  = 1'b0;
    imem_we     = 1'b0;
`endif
  end

  assign load_full = full_q;

`ifdef IMEM_LOADER_EN
  localparam int unsigned LAST = MEM_DEPTH - 1;

  logic [XLEN-1:0] ld_ptr_d;
  logic            full_d;

  // Pointer is parked at 0 outside LOAD, so it is clear on every entry.
  always_comb begin
    ld_ptr_d = ld_ptr_q;
    full_d   = full_q;
    if (state_d != ST_LOAD) begin
      ld_ptr_d = '0;
      full_d   = 1'b0;
    end else if (imem_we) begin
      if (32'(ld_ptr_q) >= LAST) full_d = 1'b1;
      else                       ld_ptr_d = ld_ptr_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      ld_ptr_q <= ld_ptr_d;
      full_q   <= full_d;
    end
  end
`else
  logic unused_loader;
  assign ld_ptr_q      = '0;
  assign full_q        = 1'b0;
  assign unused_loader = ^{load_req, load_valid};
`endif

  pc_reg #(
    .MEM_DEPTH (MEM_DEPTH),
    .RESET_PC  (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .run_i    (state_q == ST_RUN),
    .reload_i (reload),
    .halt_i   (halt_hit),
    .stall_i  (stall),
    .branch_i (branch_taken),
    .target_i (branch_target),
    .pc_o     (pc)
  );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl (loader section follows IMEM_LOADER_EN).
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req, load_valid;
  logic [15:0] load_data;
  logic        load_ready, load_full;
  logic        stall, branch_taken;
  logic [15:0] branch_target, instr;
  logic [15:0] imem_addr, imem_wdata, pc;
  logic        imem_we, fetch_valid, halted;

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] tb_mem [0:1023];
  int          wr_cnt = 0;

  imem_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .load_req      (load_req),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_ready    (load_ready),
    .load_full     (load_full),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr         (instr),
    .imem_addr     (imem_addr),
    .imem_we       (imem_we),
    .imem_wdata    (imem_wdata),
    .pc            (pc),
    .fetch_valid   (fetch_valid),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Memory model: captures every accepted write.
  always @(posedge clk) begin
    if (rst === 1'b1 && imem_we === 1'b1) begin
      tb_mem[imem_addr[9:0]] <= imem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int saved;
    rst = 1'b0; load_req = 1'b0; load_valid = 1'b1; load_data = 16'h1111;
    stall = 1'b0; branch_taken = 1'b0; branch_target = '0; instr = 16'h0000;
    #2;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_fv", 32'(fetch_valid), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_ready", 32'(load_ready), 0);
    check("rst_full", 32'(load_full), 0);
    check("rst_we", 32'(imem_we), 0);
    load_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("idle_fv", 32'(fetch_valid), 0);

    // Free run from RESET_PC
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("run_pc%0d", i), 32'(pc), 32'(i));
      check($sformatf("run_fv%0d", i), 32'(fetch_valid), 1);
    end

    branch_taken = 1'b1; branch_target = 16'h0405;
    tick(); check("branch_mod", 32'(pc), 32'h0005);
    stall = 1'b1; branch_target = 16'h0010;
    tick(); check("branch_over_stall", 32'(pc), 32'h0010);
    branch_taken = 1'b0;
    tick(); check("stall_hold", 32'(pc), 32'h0010);
    stall = 1'b0;
    tick(); check("inc_after_stall", 32'(pc), 32'h0011);
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    tick(); check("branch_ffff", 32'(pc), 32'h03FF);
    branch_taken = 1'b0;
    tick(); check("wrap", 32'(pc), 32'h0000);
    tick(); check("post_wrap", 32'(pc), 32'h0001);

    // Halt wins over a simultaneous branch
    instr = 16'hFFFF; branch_taken = 1'b1; branch_target = 16'h0020;
    tick();
    check("halt_flag", 32'(halted), 1);
    check("halt_fv", 32'(fetch_valid), 0);
    check("halt_pc", 32'(pc), 32'h0001);
    instr = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("halt_hold%0d", i), 32'(pc), 32'h0001);
    end
    check("halt_still", 32'(halted), 1);
    branch_taken = 1'b0;

`ifdef IMEM_LOADER_EN
    load_req = 1'b1;
    tick();
    check("load_entry_halted", 32'(halted), 0);
    check("load_ready", 32'(load_ready), 1);
    check("load_addr0", 32'(imem_addr), 0);
    load_valid = 1'b1; load_data = 16'hA0A0; #1;
    check("load_we", 32'(imem_we), 1);
    check("load_wdata", 32'(imem_wdata), 32'hA0A0);
    tick();
    load_data = 16'hB0B0; #1;
    check("load_addr1", 32'(imem_addr), 1);
    tick();
    load_data = 16'hC0C0; load_req = 1'b0; #1;
    check("load_addr2", 32'(imem_addr), 2);
    tick();
    load_valid = 1'b0;
    check("mem0", 32'(tb_mem[0]), 32'hA0A0);
    check("mem1", 32'(tb_mem[1]), 32'hB0B0);
    check("mem2_late_drop", 32'(tb_mem[2]), 32'hC0C0);
    check("idle_after_load_pc", 32'(pc), 0);
    check("idle_after_load_fv", 32'(fetch_valid), 0);
    tick();
    check("run_after_load_fv", 32'(fetch_valid), 1);
    check("run_after_load_pc", 32'(pc), 0);

    // Reset in the middle of a load
    instr = 16'hFFFF; tick(); instr = 16'h0000;
    load_req = 1'b1; tick();
    load_valid = 1'b1; load_data = 16'hD0D0; tick();
    load_data = 16'hE0E0; tick();
    load_data = 16'hF0F0; #1;
    check("third_pending_we", 32'(imem_we), 1);
    saved = wr_cnt;
    rst = 1'b0; #1;
    check("abort_we", 32'(imem_we), 0);
    check("abort_ready", 32'(load_ready), 0);
    tick();
    check("abort_wr_cnt", 32'(wr_cnt), 32'(saved));
    check("abort_mem0", 32'(tb_mem[0]), 32'hD0D0);
    check("abort_mem1", 32'(tb_mem[1]), 32'hE0E0);
    check("abort_mem2", 32'(tb_mem[2]), 32'hC0C0);
    rst = 1'b1;
    tick();  // IDLE with load_req high -> LOAD

    // Overflow: 1025 words offered, 1024 accepted
    saved = wr_cnt;
    for (int i = 0; i < 1024; i++) begin
      load_data = 16'(i) ^ 16'h5A5A; #1;
      if (i == 0 || i == 513 || i == 1023) begin
        check($sformatf("ovf_we%0d", i), 32'(imem_we), 1);
        check($sformatf("ovf_addr%0d", i), 32'(imem_addr), 32'(i));
        check($sformatf("ovf_full%0d", i), 32'(load_full), 0);
      end
      tick();
    end
    load_data = 16'h7777; #1;
    check("ovf_full", 32'(load_full), 1);
    check("ovf_ready", 32'(load_ready), 0);
    check("ovf_refused", 32'(imem_we), 0);
    tick();
    check("ovf_full_hold", 32'(load_full), 1);
    check("ovf_wr_cnt", 32'(wr_cnt - saved), 1024);
    check("ovf_mem_last", 32'(tb_mem[1023]), 32'(16'd1023 ^ 16'h5A5A));
    check("ovf_mem_first", 32'(tb_mem[0]), 32'h5A5A);
    load_valid = 1'b0; load_req = 1'b0;
    tick();
    check("exit_full_clear", 32'(load_full), 0);
    check("exit_idle_pc", 32'(pc), 0);
`else
    load_req = 1'b1; load_valid = 1'b1; load_data = 16'h1234; #1;
    check("noload_ready", 32'(load_ready), 0);
    check("noload_we", 32'(imem_we), 0);
    repeat (3) tick();
    check("noload_halted", 32'(halted), 1);
    check("noload_full", 32'(load_full), 0);
    check("noload_addr", 32'(imem_addr), 32'h0001);
    check("noload_wr_cnt", 32'(wr_cnt), 0);
    rst = 1'b0; #1;
    check("noload_rst_halted", 32'(halted), 0);
    check("noload_rst_pc", 32'(pc), 0);
    tick();
    rst = 1'b1;
    tick();
    check("noload_run_fv", 32'(fetch_valid), 1);
    check("noload_run_pc", 32'(pc), 0);
    load_req = 1'b0; load_valid = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
